dwc_downconv_rdata_packer: RTL and testbench
============================================

Name: dwc_downconv_rdata_packer

Overview:
Read-data return path of the down-sizing width converter. The write/command side splits one wide master burst into narrow slave beats. This block does the reverse for reads: it collects narrow slave R beats and packs them back into wide master R beats with correct byte-lane placement, merged response and master RLAST. It holds one command (one master AR) at a time, taken from the converter's read command FIFO.

Parameters:
DATA_WIDTH_IN, 64, master (wide) data width in bits; power of 2, 16..512.
DATA_WIDTH_OUT, 32, slave (narrow) data width in bits; power of 2, 8..DATA_WIDTH_IN/2.
ID_WIDTH, 4, AXI ID width.
USER_WIDTH, 1, AXI RUSER width.

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid  in  1  command available
cmd_ready  out  1  command accepted
cmd_id  in  ID_WIDTH  master ARID
cmd_addr  in  12  master ARADDR[11:0]
cmd_size  in  3  master ARSIZE
cmd_len  in  8  master ARLEN
cmd_burst  in  2  master ARBURST
SLAVE_RVALID  in  1  narrow beat valid
SLAVE_RREADY  out  1  narrow beat accept
SLAVE_RDATA  in  DATA_WIDTH_OUT  narrow data
SLAVE_RRESP  in  2  narrow response
SLAVE_RLAST  in  1  narrow last; ignored
SLAVE_RUSER  in  USER_WIDTH  narrow user
MASTER_RVALID  out  1  wide beat valid
MASTER_RREADY  in  1  wide beat accept
MASTER_RID  out  ID_WIDTH  = latched cmd_id
MASTER_RDATA  out  DATA_WIDTH_IN  packed data
MASTER_RRESP  out  2  merged response
MASTER_RLAST  out  1  last master beat
MASTER_RUSER  out  USER_WIDTH  RUSER of final sub-beat

Behaviour:
- Reset: rst, asynchronous, active-high; clock clk. Reset forces state IDLE and clears all registers to 0. While in reset, MASTER_RVALID, MASTER_RLAST, SLAVE_RREADY and all data/ID/resp outputs are 0; cmd_ready is 0 during reset. Reset mid-burst abandons the burst with no output.
- Constants: SLV_SZ = log2(DATA_WIDTH_OUT/8), MST_SZ = log2(DATA_WIDTH_IN/8). Effective slave size ssz = min(cmd_size, SLV_SZ).
- FSM states: IDLE, PACK, OUT.
  - IDLE: cmd_ready = 1. On cmd_valid, latch the command, beat_cnt = 0, clear the pack register and resp accumulator, then go to PACK.
  - Starting naddr: cmd_addr aligned down to ssz. For FIXED with cmd_size > SLV_SZ, align down to cmd_size instead.
  - PACK: SLAVE_RREADY = 1, MASTER_RVALID = 0. On each slave handshake:
    - write SLAVE_RDATA into pack lane naddr[MST_SZ-1:SLV_SZ], i.e. bits at byte offset (naddr aligned to SLV_SZ) mod DATA_WIDTH_IN/8;
    - resp_acc = max(resp_acc, SLAVE_RRESP) as unsigned;
    - latch RUSER;
    - naddr_nxt = naddr + (1<<ssz).
  - End of master beat when naddr_nxt[cmd_size-1:0] == 0 (always true for cmd_size == 0). Then go to OUT; MASTER_RVALID rises the next cycle. Otherwise set naddr = naddr_nxt and stay in PACK.
  - OUT: MASTER_RVALID = 1, SLAVE_RREADY = 0. Outputs stay stable until MASTER_RREADY. MASTER_RLAST = (beat_cnt == cmd_len).
  - On the OUT handshake:
    - if RLAST, go to IDLE;
    - else beat_cnt += 1, clear the pack register and resp_acc, update naddr per burst type, and go to PACK.
- naddr update per burst type:
  - INCR, and reserved 2'b11: naddr_nxt aligned to cmd_size.
  - FIXED: the beat start address.
  - WRAP: aligned next address with wrap inside a boundary of (cmd_len+1)<<cmd_size bytes. Address bits above the boundary are held; the low bits wrap modulo the boundary.
- Lane handling:
  - Lanes not written during a beat read as 0. The first INCR beat from an unaligned address leaves its low lanes at 0.
  - When cmd_size <= SLV_SZ, every slave beat is exactly one master beat, placed at its naddr lane.
- Throughput: one bubble cycle per master beat (no PACK during OUT). There is no back-to-back command overlap: the next command is accepted only in IDLE, the cycle after the final handshake.
- Counters: beat_cnt is 8 bits; cmd_len = 255 yields 256 master beats. naddr is 12 bits and wraps at 4 KB.

Test Plan:
- 64→32, size 3, INCR, len 1, addr 0x000; slave A,B,C,D → master {B,A}, then {D,C} with RLAST; cmd_ready back to 1 after the final handshake.
- INCR, size 3, len 1, addr 0x004; slave X,Y,Z → {X,0x0}, then {Z,Y} with RLAST (3 slave beats only).
- size 2 (no reduction), INCR, len 0, addr 0x004; slave P → {P,0x0}, RLAST = 1, RID = cmd_id.
- RRESP merge: sub-beats OKAY, SLVERR → MASTER_RRESP = 2'b10; the next beat with OKAY,OKAY → 2'b00.
- Backpressure: MASTER_RREADY low for 3 cycles in OUT → RDATA, RRESP and RLAST stable; SLAVE_RREADY = 0 throughout; no slave beat lost.
- WRAP, size 3, len 3, addr 0x010 → master beats sourced from 0x10, 0x18, 0x00, 0x08 (8 slave beats). FIXED, size 3, len 2, addr 0x020 → 3 master beats of 2 sub-beats each, all lanes from offset 0x20. Assert rst mid-beat → all outputs 0 immediately, FSM returns to IDLE.

Source files
------------

// File: rtl/dwc_downconv_rdata_packer.sv
// Read-data packer for the down-sizing width converter: collects narrow slave R beats
// and rebuilds wide master R beats with byte-lane placement, merged RRESP and RLAST.
// One master read command is held at a time.
module dwc_downconv_rdata_packer #(
  parameter int unsigned DATA_WIDTH_IN  = 64,
  parameter int unsigned DATA_WIDTH_OUT = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned USER_WIDTH     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ID_WIDTH-1:0]       cmd_id,
  input  logic [11:0]               cmd_addr,
  input  logic [2:0]                cmd_size,
  input  logic [7:0]                cmd_len,
  input  logic [1:0]                cmd_burst,
  input  logic                      SLAVE_RVALID,
  output logic                      SLAVE_RREADY,
  input  logic [DATA_WIDTH_OUT-1:0] SLAVE_RDATA,
  input  logic [1:0]                SLAVE_RRESP,
  input  logic                      SLAVE_RLAST,
  input  logic [USER_WIDTH-1:0]     SLAVE_RUSER,
  output logic                      MASTER_RVALID,
  input  logic                      MASTER_RREADY,
  output logic [ID_WIDTH-1:0]       MASTER_RID,
  output logic [DATA_WIDTH_IN-1:0]  MASTER_RDATA,
  output logic [1:0]                MASTER_RRESP,
  output logic                      MASTER_RLAST,
  output logic [USER_WIDTH-1:0]     MASTER_RUSER
);

  localparam int unsigned SlvSz = $clog2(DATA_WIDTH_OUT / 8);
  localparam int unsigned MstSz = $clog2(DATA_WIDTH_IN / 8);
  localparam int unsigned Lanes = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int unsigned LaneW = MstSz - SlvSz;
  localparam logic [2:0]  SlvSzL = 3'(SlvSz);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PACK = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;

  logic [1:0]                state_q, state_d;
  logic [ID_WIDTH-1:0]       id_q, id_d;
  logic [2:0]                size_q, size_d;
  logic [7:0]                len_q, len_d;
  logic [1:0]                burst_q, burst_d;
  logic [11:0]               naddr_q, naddr_d;
  logic [11:0]               baddr_q, baddr_d;  // size-aligned start of the current master beat
  logic [7:0]                beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH_IN-1:0]  pack_q, pack_d;
  logic [1:0]                resp_q, resp_d;
  logic [USER_WIDTH-1:0]     user_q, user_d;

  // RLAST on the slave side carries no information here; beat ends come from addresses.
  logic unused_rlast;
  assign unused_rlast = SLAVE_RLAST;

  function automatic logic [11:0] align_down(input logic [11:0] a, input logic [2:0] s);
    return a & (12'hFFF << s);
  endfunction

  logic [2:0]       ssz_cmd, ssz_cur;
  logic [11:0]      naddr_nxt, wrap_mask, incr_addr, wrap_addr, next_baddr;
  logic             beat_end;
  logic [LaneW-1:0] lane;

  // Address arithmetic for sub-beat stepping and master beat sequencing
  always_comb begin
    ssz_cmd    = (cmd_size > SlvSzL) ? SlvSzL : cmd_size;
    ssz_cur    = (size_q > SlvSzL) ? SlvSzL : size_q;
    naddr_nxt  = naddr_q + (12'd1 << ssz_cur);
    beat_end   = (naddr_nxt & ~(12'hFFF << size_q)) == 12'd0;
    lane       = naddr_q[MstSz-1:SlvSz];
    wrap_mask  = (({4'd0, len_q} + 12'd1) << size_q) - 12'd1;
    incr_addr  = baddr_q + (12'd1 << size_q);
    wrap_addr  = (baddr_q & ~wrap_mask) | (incr_addr & wrap_mask);
    if (burst_q == BurstFixed) begin
      next_baddr = baddr_q;
    end else if (burst_q == BurstWrap) begin
      next_baddr = wrap_addr;
    end else begin
      next_baddr = incr_addr;
    end
  end

  // Packing FSM next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    size_d     = size_q;
    len_d      = len_q;
    burst_d    = burst_q;
    naddr_d    = naddr_q;
    baddr_d    = baddr_q;
    beat_cnt_d = beat_cnt_q;
    pack_d     = pack_q;
    resp_d     = resp_q;
    user_d     = user_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          id_d       = cmd_id;
          size_d     = cmd_size;
          len_d      = cmd_len;
          burst_d    = cmd_burst;
          // FIXED bursts wider than the slave restart every beat at the size-aligned address
          naddr_d    = (cmd_burst == BurstFixed && cmd_size > SlvSzL) ?
                       align_down(cmd_addr, cmd_size) : align_down(cmd_addr, ssz_cmd);
          baddr_d    = align_down(cmd_addr, cmd_size);
          beat_cnt_d = 8'd0;
          pack_d     = '0;
          resp_d     = 2'b00;
          user_d     = '0;
          state_d    = PACK;
        end
      end
      PACK: begin
        if (SLAVE_RVALID) begin
          for (int unsigned i = 0; i < Lanes; i++) begin
            if (lane == LaneW'(i)) pack_d[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT] = SLAVE_RDATA;
          end
          if (SLAVE_RRESP > resp_q) resp_d = SLAVE_RRESP;
          user_d = SLAVE_RUSER;
          if (beat_end) begin
            state_d = OUT;
          end else begin
            naddr_d = naddr_nxt;
          end
        end
      end
      OUT: begin
        if (MASTER_RREADY) begin
          if (beat_cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            pack_d     = '0;
            resp_d     = 2'b00;
            naddr_d    = next_baddr;
            baddr_d    = next_baddr;
            state_d    = PACK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= '0;
      size_q     <= 3'd0;
      len_q      <= 8'd0;
      burst_q    <= 2'b00;
      naddr_q    <= 12'd0;
      baddr_q    <= 12'd0;
      beat_cnt_q <= 8'd0;
      pack_q     <= '0;
      resp_q     <= 2'b00;
      user_q     <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      size_q     <= size_d;
      len_q      <= len_d;
      burst_q    <= burst_d;
      naddr_q    <= naddr_d;
      baddr_q    <= baddr_d;
      beat_cnt_q <= beat_cnt_d;
      pack_q     <= pack_d;
      resp_q     <= resp_d;
      user_q     <= user_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE) && !rst;
  assign SLAVE_RREADY  = (state_q == PACK);
  assign MASTER_RVALID = (state_q == OUT);
  assign MASTER_RLAST  = (state_q == OUT) && (beat_cnt_q == len_q);
  assign MASTER_RID    = id_q;
  assign MASTER_RDATA  = pack_q;
  assign MASTER_RRESP  = resp_q;
  assign MASTER_RUSER  = user_q;

endmodule

// File: tb/tb_dwc_downconv_rdata_packer.sv
// Bench for the read-data packer: per-burst reference model built from AXI burst address
// rules, random slave data/resp/user, and randomised slave valid / master ready timing.
module tb_dwc_downconv_rdata_packer;

  localparam int DW_IN  = 64;
  localparam int DW_OUT = 32;
  localparam int IDW    = 4;
  localparam int UW     = 1;
  localparam int MB     = DW_IN / 8;
  localparam int SB     = DW_OUT / 8;
  localparam int SLV_SZ = $clog2(SB);

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [IDW-1:0]    cmd_id;
  logic [11:0]       cmd_addr;
  logic [2:0]        cmd_size;
  logic [7:0]        cmd_len;
  logic [1:0]        cmd_burst;
  logic              SLAVE_RVALID;
  logic              SLAVE_RREADY;
  logic [DW_OUT-1:0] SLAVE_RDATA;
  logic [1:0]        SLAVE_RRESP;
  logic              SLAVE_RLAST;
  logic [UW-1:0]     SLAVE_RUSER;
  logic              MASTER_RVALID;
  logic              MASTER_RREADY;
  logic [IDW-1:0]    MASTER_RID;
  logic [DW_IN-1:0]  MASTER_RDATA;
  logic [1:0]        MASTER_RRESP;
  logic              MASTER_RLAST;
  logic [UW-1:0]     MASTER_RUSER;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW_OUT-1:0] sq_data[$];
  logic [1:0]        sq_resp[$];
  logic [UW-1:0]     sq_user[$];
  logic [DW_IN-1:0]  eq_data[$];
  logic [1:0]        eq_resp[$];
  logic [UW-1:0]     eq_user[$];
  logic              eq_last[$];

  dwc_downconv_rdata_packer #(
    .DATA_WIDTH_IN (DW_IN),
    .DATA_WIDTH_OUT(DW_OUT),
    .ID_WIDTH      (IDW),
    .USER_WIDTH    (UW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_id       (cmd_id),
    .cmd_addr     (cmd_addr),
    .cmd_size     (cmd_size),
    .cmd_len      (cmd_len),
    .cmd_burst    (cmd_burst),
    .SLAVE_RVALID (SLAVE_RVALID),
    .SLAVE_RREADY (SLAVE_RREADY),
    .SLAVE_RDATA  (SLAVE_RDATA),
    .SLAVE_RRESP  (SLAVE_RRESP),
    .SLAVE_RLAST  (SLAVE_RLAST),
    .SLAVE_RUSER  (SLAVE_RUSER),
    .MASTER_RVALID(MASTER_RVALID),
    .MASTER_RREADY(MASTER_RREADY),
    .MASTER_RID   (MASTER_RID),
    .MASTER_RDATA (MASTER_RDATA),
    .MASTER_RRESP (MASTER_RRESP),
    .MASTER_RLAST (MASTER_RLAST),
    .MASTER_RUSER (MASTER_RUSER)
  );

  always #5 clk = ~clk;

  // Reference model: AXI beat addresses -> sub-beat byte addresses -> lane placement.
  // resp_mode 1 makes the second slave beat SLVERR and all others OKAY.
  task automatic build_model(input int addr, input int size, input int len, input int burst,
                             input int resp_mode);
    int bsz, ssb, wlen, wbase, a, s, e, sub;
    logic [DW_IN-1:0]  d;
    logic [1:0]        r;
    logic [UW-1:0]     u;
    logic [DW_OUT-1:0] sd;
    logic [1:0]        sr;
    logic [UW-1:0]     su;
    sq_data.delete(); sq_resp.delete(); sq_user.delete();
    eq_data.delete(); eq_resp.delete(); eq_user.delete(); eq_last.delete();
    bsz   = 1 << size;
    ssb   = 1 << ((size > SLV_SZ) ? SLV_SZ : size);
    wlen  = (len + 1) * bsz;
    wbase = (((addr / bsz) * bsz) / wlen) * wlen;
    sub   = 0;
    for (int n = 0; n <= len; n++) begin
      case (burst)
        0:       a = addr;
        2:       a = wbase + ((((addr / bsz) * bsz) - wbase + n * bsz) % wlen);
        default: a = (n == 0) ? addr : ((addr / bsz) * bsz + n * bsz);
      endcase
      a = a % 4096;
      if (burst == 0 && size > SLV_SZ) s = (a / bsz) * bsz;
      else s = (a / ssb) * ssb;
      e = (a / bsz) * bsz + bsz;
      d = '0; r = 2'b00; u = '0;
      for (int b = s; b < e; b += ssb) begin
        sd = DW_OUT'($urandom);
        sr = (resp_mode == 1) ? ((sub == 1) ? 2'b10 : 2'b00) : 2'($urandom_range(0, 3));
        su = UW'($urandom);
        d[((b % MB) / SB) * DW_OUT +: DW_OUT] = sd;
        if (sr > r) r = sr;
        u = su;
        sq_data.push_back(sd); sq_resp.push_back(sr); sq_user.push_back(su);
        sub++;
      end
      eq_data.push_back(d); eq_resp.push_back(r); eq_user.push_back(u);
      eq_last.push_back(n == len);
    end
  endtask

  // Issues one command and plays it out. rmode: 0 always ready, 1 random, 2 hold 3 cycles.
  // smode: 0 slave always valid, 1 random gaps.
  task automatic run_cmd(input string name, input int addr, input int size, input int len,
                         input int burst, input int resp_mode, input int rmode, input int smode);
    logic [IDW-1:0]   id;
    int               cyc, stall, beat;
    logic             pv;
    logic [DW_IN-1:0] p_data;
    logic [1:0]       p_resp;
    logic             p_last;
    id = IDW'($urandom);
    build_model(addr, size, len, burst, resp_mode);
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cmd_ready before issue: got %b want 1", name, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = 12'(addr); cmd_size = 3'(size);
    cmd_len = 8'(len); cmd_burst = 2'(burst);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0; stall = 0; beat = 0; pv = 1'b0;
    p_data = '0; p_resp = 2'b00; p_last = 1'b0;
    while (eq_data.size() > 0 && cyc < 4000) begin
      SLAVE_RVALID = (sq_data.size() > 0) && (smode == 0 || $urandom_range(0, 1) == 1);
      if (sq_data.size() > 0) begin
        SLAVE_RDATA = sq_data[0]; SLAVE_RRESP = sq_resp[0]; SLAVE_RUSER = sq_user[0];
        SLAVE_RLAST = (sq_data.size() == 1);
      end
      case (rmode)
        0: MASTER_RREADY = 1'b1;
        1: MASTER_RREADY = ($urandom_range(0, 1) == 1);
        default: begin
          if (MASTER_RVALID && stall < 3) begin
            MASTER_RREADY = 1'b0; stall++;
          end else begin
            MASTER_RREADY = 1'b1;
          end
        end
      endcase
      @(negedge clk);
      if (pv) begin
        n_checks++;
        if (MASTER_RVALID !== 1'b1 || MASTER_RDATA !== p_data || MASTER_RRESP !== p_resp ||
            MASTER_RLAST !== p_last) begin
          n_fail++;
          $display("FAIL %s hold beat%0d: valid %b data %h resp %0d last %b, want 1 %h %0d %b",
                   name, beat, MASTER_RVALID, MASTER_RDATA, MASTER_RRESP, MASTER_RLAST,
                   p_data, p_resp, p_last);
        end
      end
      if (MASTER_RVALID === 1'b1) begin
        n_checks++;
        if (SLAVE_RREADY !== 1'b0) begin
          n_fail++;
          $display("FAIL %s slave_rready in out: got %b want 0", name, SLAVE_RREADY);
        end
      end
      pv = MASTER_RVALID && !MASTER_RREADY;
      p_data = MASTER_RDATA; p_resp = MASTER_RRESP; p_last = MASTER_RLAST;
      if (SLAVE_RVALID && SLAVE_RREADY) begin
        void'(sq_data.pop_front()); void'(sq_resp.pop_front()); void'(sq_user.pop_front());
      end
      if (MASTER_RVALID && MASTER_RREADY) begin
        n_checks++;
        if (MASTER_RDATA !== eq_data[0] || MASTER_RRESP !== eq_resp[0] ||
            MASTER_RLAST !== eq_last[0] || MASTER_RUSER !== eq_user[0] || MASTER_RID !== id) begin
          n_fail++;
          $display("FAIL %s beat%0d: data %h resp %0d last %b user %b id %h, want %h %0d %b %b %h",
                   name, beat, MASTER_RDATA, MASTER_RRESP, MASTER_RLAST, MASTER_RUSER,
                   MASTER_RID, eq_data[0], eq_resp[0], eq_last[0], eq_user[0], id);
        end
        void'(eq_data.pop_front()); void'(eq_resp.pop_front());
        void'(eq_user.pop_front()); void'(eq_last.pop_front());
        stall = 0; beat++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    SLAVE_RVALID = 1'b0; MASTER_RREADY = 1'b0;
    n_checks++;
    if (eq_data.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d master beats missing, want 0", name, eq_data.size());
    end
    n_checks++;
    if (sq_data.size() != 0) begin
      n_fail++;
      $display("FAIL %s slave beats left: got %0d want 0", name, sq_data.size());
    end
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || MASTER_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after last: cmd_ready %b valid %b, want 1 0", name, cmd_ready,
               MASTER_RVALID);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_checks++;
    if (cmd_ready !== 1'b0 || SLAVE_RREADY !== 1'b0 || MASTER_RVALID !== 1'b0 ||
        MASTER_RLAST !== 1'b0 || MASTER_RDATA !== '0 || MASTER_RID !== '0 ||
        MASTER_RRESP !== 2'b00 || MASTER_RUSER !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: cmd_ready %b srdy %b mvalid %b last %b data %h id %h",
               cmd_ready, SLAVE_RREADY, MASTER_RVALID, MASTER_RLAST, MASTER_RDATA, MASTER_RID);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_incr_aligned;
    run_cmd("incr_aligned", 12'h000, 3, 1, 1, 0, 0, 0);
  endtask

  task automatic test_incr_unaligned;
    run_cmd("incr_unaligned", 12'h004, 3, 1, 1, 0, 0, 0);
  endtask

  task automatic test_no_reduction;
    run_cmd("size2_len0", 12'h004, 2, 0, 1, 0, 0, 0);
    run_cmd("size0_incr", 12'h003, 0, 5, 1, 0, 1, 1);
    run_cmd("size1_incr", 12'h00E, 1, 4, 1, 0, 1, 1);
  endtask

  task automatic test_resp_merge;
    run_cmd("resp_merge", 12'h000, 3, 1, 1, 1, 0, 0);
  endtask

  task automatic test_backpressure;
    run_cmd("backpressure", 12'h040, 3, 2, 1, 0, 2, 0);
  endtask

  task automatic test_wrap_fixed;
    run_cmd("wrap", 12'h010, 3, 3, 2, 0, 0, 0);
    run_cmd("fixed", 12'h020, 3, 2, 0, 0, 0, 0);
  endtask

  task automatic test_long_4k_wrap;
    run_cmd("len255", 12'hF00, 3, 255, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid_beat;
    @(negedge clk);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_id = 4'hA; cmd_addr = 12'h000; cmd_size = 3'd3;
    cmd_len = 8'd1; cmd_burst = 2'b01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    SLAVE_RVALID = 1'b1; SLAVE_RDATA = 32'hDEADBEEF; SLAVE_RRESP = 2'b11; SLAVE_RUSER = 1'b1;
    @(posedge clk); #1;
    SLAVE_RVALID = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (cmd_ready !== 1'b0 || SLAVE_RREADY !== 1'b0 || MASTER_RVALID !== 1'b0 ||
        MASTER_RLAST !== 1'b0 || MASTER_RDATA !== '0 || MASTER_RID !== '0 ||
        MASTER_RRESP !== 2'b00 || MASTER_RUSER !== '0) begin
      n_fail++;
      $display("FAIL mid_reset outputs: cmd_ready %b srdy %b mvalid %b data %h id %h resp %0d",
               cmd_ready, SLAVE_RREADY, MASTER_RVALID, MASTER_RDATA, MASTER_RID, MASTER_RRESP);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || SLAVE_RREADY !== 1'b0 || MASTER_RVALID !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset idle: cmd_ready %b srdy %b mvalid %b, want 1 0 0",
               cmd_ready, SLAVE_RREADY, MASTER_RVALID);
    end
    run_cmd("after_reset", 12'h008, 3, 1, 1, 0, 0, 0);
  endtask

  task automatic test_random;
    int size, burst, len, addr, sel;
    for (int k = 0; k < 30; k++) begin
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
      if (burst == 2) begin
        sel  = $urandom_range(0, 3);
        len  = (2 << sel) - 1;
        addr = ($urandom_range(0, 4095) >> size) << size;
      end else begin
        len  = $urandom_range(0, 7);
        addr = $urandom_range(0, 4095);
      end
      run_cmd("random", addr, size, len, burst, 0, $urandom_range(0, 2), $urandom_range(0, 1));
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_size = '0; cmd_len = '0;
    cmd_burst = '0; SLAVE_RVALID = 1'b0; SLAVE_RDATA = '0; SLAVE_RRESP = '0;
    SLAVE_RLAST = 1'b0; SLAVE_RUSER = '0; MASTER_RREADY = 1'b0;
    test_reset();
    test_incr_aligned();
    test_incr_unaligned();
    test_no_reduction();
    test_resp_merge();
    test_backpressure();
    test_wrap_fixed();
    test_reset_mid_beat();
    test_long_4k_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
